// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables, bubbles, PC select and data-memory timeout.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
`timescale 1ns/1ps
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic [4:0]       rd_EX,
    input  logic             MemRead_EX,
    input  logic             jal_ID,
    input  logic             redirect_EX,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic             IF_ID_en,
    output logic             ID_EX_en,
    output logic             EX_MEM_en,
    output logic             MEM_WB_en,
    output logic             IF_ID_flush,
    output logic             ID_EX_flush,
    output logic [1:0]       pc_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalt    = 2'd2
    } state_e;

    state_e           state_q;
    logic [WaitW-1:0] wait_q;
    logic             load_use;
    logic             mem_freeze;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StRun;
            wait_q  <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (dmem_req && !dmem_ready) begin
                        state_q <= StMemWait;
                        wait_q  <= '0;
                    end
                end
                StMemWait: begin
                    // A ready in the last allowed cycle still completes the access.
                    if (dmem_ready) begin
                        state_q <= StRun;
                    end else if (wait_q == WaitLast) begin
                        state_q <= StHalt;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StHalt: state_q <= StHalt;
                default: state_q <= StRun;
            endcase
        end
    end

    assign load_use = MemRead_EX && (rd_EX != 5'd0) && ((rd_EX == rs1_ID) || (rd_EX == rs2_ID));
    assign mem_freeze = ((state_q == StRun) && dmem_req && !dmem_ready) ||
                        ((state_q == StMemWait) && !dmem_ready);
    assign mem_err = (state_q == StHalt);

    always_comb begin
        pc_en       = 1'b1;
        IF_ID_en    = 1'b1;
        ID_EX_en    = 1'b1;
        EX_MEM_en   = 1'b1;
        MEM_WB_en   = 1'b1;
        IF_ID_flush = 1'b0;
        ID_EX_flush = 1'b0;
        pc_sel      = 2'b00;
        if (rst) begin
            {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en} = 5'b00000;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (state_q == StHalt || mem_freeze) begin
            {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en} = 5'b00000;
        end else if (redirect_EX) begin
            pc_sel      = 2'b10;
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            IF_ID_en    = 1'b0;
            ID_EX_flush = 1'b1;
        end else if (jal_ID) begin
            pc_sel      = 2'b01;
            IF_ID_flush = 1'b1;
        end else if (!imem_ready) begin
            pc_en       = 1'b0;
            IF_ID_flush = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_en) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (IF_ID_flush || ID_EX_flush) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized traffic vs a model.
`timescale 1ns/1ps
module tb_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CW      = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1_ID, rs2_ID, rd_EX;
    logic          MemRead_EX, jal_ID, redirect_EX, dmem_req, dmem_ready, imem_ready;
    logic          pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en;
    logic          IF_ID_flush, ID_EX_flush, mem_err;
    logic [1:0]    pc_sel;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: length of the current unready run of an access (0 = none pending), halted flag.
    int m_pend;
    bit m_halted;
    int m_stall;
    int m_flush;

    // Vector layout: {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en, IF_ID_fl, ID_EX_fl,
    // pc_sel[1:0], mem_err}
    logic [9:0] dut_vec;
    logic [9:0] exp_vec;
    assign dut_vec = {pc_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
                      IF_ID_flush, ID_EX_flush, pc_sel, mem_err};

    hazard_ctrl #(
        .MEM_TIMEOUT(TIMEOUT),
        .CNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs1_ID     (rs1_ID),
        .rs2_ID     (rs2_ID),
        .rd_EX      (rd_EX),
        .MemRead_EX (MemRead_EX),
        .jal_ID     (jal_ID),
        .redirect_EX(redirect_EX),
        .dmem_req   (dmem_req),
        .dmem_ready (dmem_ready),
        .imem_ready (imem_ready),
        .pc_en      (pc_en),
        .IF_ID_en   (IF_ID_en),
        .ID_EX_en   (ID_EX_en),
        .EX_MEM_en  (EX_MEM_en),
        .MEM_WB_en  (MEM_WB_en),
        .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush),
        .pc_sel     (pc_sel),
        .mem_err    (mem_err),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] model_out();
        bit waiting;
        bit hazard;
        waiting = (m_pend > 0);
        hazard  = MemRead_EX && rd_EX != 0 && (rd_EX == rs1_ID || rd_EX == rs2_ID);
        if (rst)                                  return 10'b00000_11_00_0;
        if (m_halted)                             return 10'b00000_00_00_1;
        if (waiting && !dmem_ready)               return 10'b00000_00_00_0;
        if (!waiting && dmem_req && !dmem_ready)  return 10'b00000_00_00_0;
        if (redirect_EX)                          return 10'b11111_11_10_0;
        if (hazard)                               return 10'b00111_01_00_0;
        if (jal_ID)                               return 10'b11111_10_01_0;
        if (!imem_ready)                          return 10'b01111_10_00_0;
        return 10'b11111_00_00_0;
    endfunction

    function automatic logic [CW-1:0] exp_stall();
`ifdef HAZARD_PERF_CNT_EN
        return CW'(m_stall);
`else
        return '0;
`endif
    endfunction

    function automatic logic [CW-1:0] exp_flush();
`ifdef HAZARD_PERF_CNT_EN
        return CW'(m_flush);
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        m_pend   = 0;
        m_halted = 0;
        m_stall  = 0;
        m_flush  = 0;
    endtask

    task automatic set_idle();
        rs1_ID = 5'd1; rs2_ID = 5'd2; rd_EX = 5'd0;
        MemRead_EX = 0; jal_ID = 0; redirect_EX = 0;
        dmem_req = 0; dmem_ready = 1; imem_ready = 1;
    endtask

    // Advance the model by one clock with the current inputs, then move to the next negedge.
    task automatic tick();
        logic [9:0] e;
        e = model_out();
        if (rst) begin
            model_reset();
        end else begin
            if (!e[9]) m_stall = (m_stall + 1) % (1 << CW);
            if (e[4] || e[3]) m_flush = (m_flush + 1) % (1 << CW);
            if (!m_halted) begin
                if (m_pend > 0) begin
                    if (dmem_ready) begin
                        m_pend = 0;
                    end else begin
                        m_pend++;
                        if (m_pend == TIMEOUT + 1) m_halted = 1;
                    end
                end else if (dmem_req && !dmem_ready) begin
                    m_pend = 1;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        set_idle();
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec !== 10'b00000_11_00_0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", dut_vec, 10'b00000_11_00_0);
        end
        n_cmp++;
        if (stall_cnt !== '0 || flush_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        n_cmp++;
        if (dut_vec !== 10'b11111_00_00_0) begin
            n_fail++;
            $display("FAIL post_reset_defaults: got %b want %b", dut_vec, 10'b11111_00_00_0);
        end
        tick();
    endtask

    task automatic test_load_use();
        set_idle();
        MemRead_EX = 1; rd_EX = 5'd5; rs1_ID = 5'd7; rs2_ID = 5'd5;
        #1;
        n_cmp++;
        if (dut_vec !== 10'b00111_01_00_0) begin
            n_fail++;
            $display("FAIL load_use_stall: got %b want %b", dut_vec, 10'b00111_01_00_0);
        end
        tick();
        MemRead_EX = 0; rd_EX = 5'd0;
        #1;
        n_cmp++;
        if (dut_vec !== 10'b11111_00_00_0) begin
            n_fail++;
            $display("FAIL load_use_release: got %b want %b", dut_vec, 10'b11111_00_00_0);
        end
        tick();
    endtask

    task automatic test_rd_zero();
        set_idle();
        MemRead_EX = 1; rd_EX = 5'd0; rs1_ID = 5'd0; rs2_ID = 5'd3;
        #1;
        n_cmp++;
        if (dut_vec !== 10'b11111_00_00_0) begin
            n_fail++;
            $display("FAIL rd_zero_no_stall: got %b want %b", dut_vec, 10'b11111_00_00_0);
        end
        tick();
    endtask

    task automatic test_redirect_priority();
        set_idle();
        redirect_EX = 1; MemRead_EX = 1; rd_EX = 5'd3; rs1_ID = 5'd3;
        jal_ID = 1; imem_ready = 0;
        #1;
        n_cmp++;
        if (dut_vec !== 10'b11111_11_10_0) begin
            n_fail++;
            $display("FAIL redirect_over_load_use: got %b want %b", dut_vec, 10'b11111_11_10_0);
        end
        tick();
    endtask

    task automatic test_mem_wait();
        set_idle();
        pulse_reset();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (dut_vec !== 10'b00000_00_00_0) begin
                n_fail++;
                $display("FAIL mem_wait_freeze[%0d]: got %b want %b", i, dut_vec,
                         10'b00000_00_00_0);
            end
            tick();
        end
        dmem_ready = 1;
        #1;
        n_cmp++;
        if (dut_vec !== 10'b11111_00_00_0) begin
            n_fail++;
            $display("FAIL mem_wait_release: got %b want %b", dut_vec, 10'b11111_00_00_0);
        end
        tick();
        // Back in RUN: an idle data bus with ready low must not freeze.
        dmem_req = 0; dmem_ready = 0;
        #1;
        n_cmp++;
        if (dut_vec !== 10'b11111_00_00_0) begin
            n_fail++;
            $display("FAIL mem_wait_back_in_run: got %b want %b", dut_vec, 10'b11111_00_00_0);
        end
        tick();
        dmem_req = 1; dmem_ready = 1;
        #1;
        n_cmp++;
        if (dut_vec !== 10'b11111_00_00_0) begin
            n_fail++;
            $display("FAIL zero_cycle_access: got %b want %b", dut_vec, 10'b11111_00_00_0);
        end
        tick();
        n_cmp++;
`ifdef HAZARD_PERF_CNT_EN
        if (stall_cnt !== CW'(3)) begin
            n_fail++;
            $display("FAIL mem_wait_stall_cnt: got %0d want 3", stall_cnt);
        end
`else
        if (stall_cnt !== CW'(0)) begin
            n_fail++;
            $display("FAIL mem_wait_stall_cnt: got %0d want 0", stall_cnt);
        end
`endif
        set_idle();
    endtask

    task automatic test_timeout();
        set_idle();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i <= TIMEOUT; i++) begin
            #1;
            n_cmp++;
            if (dut_vec !== 10'b00000_00_00_0) begin
                n_fail++;
                $display("FAIL timeout_freeze[%0d]: got %b want %b", i, dut_vec,
                         10'b00000_00_00_0);
            end
            tick();
        end
        #1;
        n_cmp++;
        if (dut_vec !== 10'b00000_00_00_1) begin
            n_fail++;
            $display("FAIL timeout_halt: got %b want %b", dut_vec, 10'b00000_00_00_1);
        end
        dmem_ready = 1; dmem_req = 0;
        tick();
        tick();
        #1;
        n_cmp++;
        if (dut_vec !== 10'b00000_00_00_1) begin
            n_fail++;
            $display("FAIL halt_sticky: got %b want %b", dut_vec, 10'b00000_00_00_1);
        end
        // Reset between clock edges must clear mem_err immediately.
        #1;
        rst = 1;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec !== 10'b00000_11_00_0) begin
            n_fail++;
            $display("FAIL halt_async_reset: got %b want %b", dut_vec, 10'b00000_11_00_0);
        end
        @(negedge clk);
        rst = 0;
        #1;
        n_cmp++;
        if (dut_vec !== 10'b11111_00_00_0) begin
            n_fail++;
            $display("FAIL halt_reset_run: got %b want %b", dut_vec, 10'b11111_00_00_0);
        end
        tick();
    endtask

    task automatic test_jal_imem();
        set_idle();
        jal_ID = 1; imem_ready = 0;
        #1;
        n_cmp++;
        if (dut_vec !== 10'b11111_10_01_0) begin
            n_fail++;
            $display("FAIL jal_unready_fetch: got %b want %b", dut_vec, 10'b11111_10_01_0);
        end
        tick();
        jal_ID = 0;
        #1;
        n_cmp++;
        if (dut_vec !== 10'b01111_10_00_0) begin
            n_fail++;
            $display("FAIL imem_not_ready: got %b want %b", dut_vec, 10'b01111_10_00_0);
        end
        tick();
        n_cmp++;
        if (stall_cnt !== exp_stall() || flush_cnt !== exp_flush()) begin
            n_fail++;
            $display("FAIL jal_counters: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt,
                     exp_stall(), exp_flush());
        end
        set_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rs1_ID      = 5'($urandom_range(0, 3));
            rs2_ID      = 5'($urandom_range(0, 3));
            rd_EX       = 5'($urandom_range(0, 3));
            MemRead_EX  = ($urandom_range(0, 1) == 1);
            redirect_EX = ($urandom_range(0, 7) == 0);
            jal_ID      = ($urandom_range(0, 7) == 0);
            imem_ready  = ($urandom_range(0, 4) != 0);
            dmem_req    = ($urandom_range(0, 9) < 3);
            dmem_ready  = ($urandom_range(0, 9) < 6);
            rst         = ($urandom_range(0, 39) == 0);
            if (rst) model_reset();
            #1;
            exp_vec = model_out();
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL random_outputs[%0d]: got %b want %b", i, dut_vec, exp_vec);
            end
            n_cmp++;
            if (stall_cnt !== exp_stall() || flush_cnt !== exp_flush()) begin
                n_fail++;
                $display("FAIL random_counters[%0d]: got %0d/%0d want %0d/%0d", i, stall_cnt,
                         flush_cnt, exp_stall(), exp_flush());
            end
            tick();
        end
        rst = 0;
        set_idle();
    endtask

    task automatic test_wrap();
        set_idle();
        pulse_reset();
        imem_ready = 0;
        for (int i = 0; i < 300; i++) tick();
        imem_ready = 1;
        #1;
        n_cmp++;
`ifdef HAZARD_PERF_CNT_EN
        if (stall_cnt !== CW'(300 % 256) || flush_cnt !== CW'(300 % 256)) begin
            n_fail++;
            $display("FAIL counter_wrap: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt,
                     300 % 256, 300 % 256);
        end
`else
        if (stall_cnt !== CW'(0) || flush_cnt !== CW'(0)) begin
            n_fail++;
            $display("FAIL counter_wrap: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_rd_zero();
        test_redirect_priority();
        test_mem_wait();
        test_timeout();
        test_jal_imem();
        test_random();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
